universal_shift_reg: RTL and testbench

Parametrised universal shift register, the successor to the 3-bit serial-in/serial-out register. It supports a configurable width and four modes: hold, shift right, shift left and parallel load. It exposes serial outputs at both ends and a frame counter that flags every WIDTH consecutive shifts. It sits between serial links and parallel datapaths as a SISO, SIPO, PISO or PIPO stage.

---
 rtl/universal_shift_reg.sv | 82 ++++++++
 tb/tb_universal_shift_reg.sv | 136 +++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register: hold, shift right/left, parallel load,
// with serial taps at both ends and a frame counter that pulses every WIDTH shifts.
module universal_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             frame_done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_p0;
  logic [CW-1:0]    cnt_p0;
  logic             vld_p0;

  // Next register contents; each serial input is only selected in its own mode,
  // so an undriven input on the unused side never reaches the register.
  function automatic logic [WIDTH-1:0] next_q(input logic [1:0] m,
                                               input logic [WIDTH-1:0] cur,
                                               input logic sr,
                                               input logic sl,
                                               input logic [WIDTH-1:0] ld);
    logic [WIDTH-1:0] r;
    r = cur;
    case (m)
      MODE_RIGHT: r = {sr, cur[WIDTH-1:1]};
      MODE_LEFT:  r = {cur[WIDTH-2:0], sl};
      MODE_LOAD:  r = ld;
      default:    r = cur;
    endcase
    return r;
  endfunction

  logic is_shift;
  assign is_shift = (mode == MODE_RIGHT) || (mode == MODE_LEFT);

  // Stage p0: register, frame counter and registered frame pulse
  always_ff @(posedge clk) begin
    if (clr) begin
      q_p0   <= '0;
      cnt_p0 <= '0;
      vld_p0 <= 1'b0;
    end else begin
      q_p0   <= next_q(mode, q_p0, sin_r, sin_l, pin);
      vld_p0 <= 1'b0;
      if (mode == MODE_LOAD) begin
        cnt_p0 <= '0;
      end else if (is_shift) begin
        if (cnt_p0 == CNT_LAST) begin
          cnt_p0 <= '0;
          vld_p0 <= 1'b1;
        end else begin
          cnt_p0 <= cnt_p0 + CW'(1);
        end
      end else if (mode == MODE_HOLD) begin
        cnt_p0 <= cnt_p0;
      end
    end
  end

  assign q          = q_p0;
  assign sout_r     = q_p0[0];
  assign sout_l     = q_p0[WIDTH-1];
  assign cnt        = cnt_p0;
  assign frame_done = vld_p0;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg (WIDTH=4): directed vectors push
// hand-computed expectations; a monitor pops one entry per clock and compares.
module tb_universal_shift_reg;

  localparam int WIDTH = 4;
  localparam int CW    = 2;

  logic             clk;
  logic             clr;
  logic [1:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    cnt;
  logic             frame_done;

  universal_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .clr(clr), .mode(mode), .sin_r(sin_r), .sin_l(sin_l), .pin(pin),
    .q(q), .sout_r(sout_r), .sout_l(sout_l), .cnt(cnt), .frame_done(frame_done)
  );

  typedef struct packed {
    logic [15:0]      id;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;
    logic             fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_id  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int id, input logic [7:0] act,
                       input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s step %0d: got %0h, expected %0h", name, id, act, req);
  endtask

  // Monitor: one expectation per rising edge, sampled 1 time unit after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("q",          int'(e.id), 8'(q),          8'(e.q));
        check("cnt",        int'(e.id), 8'(cnt),        8'(e.cnt));
        check("frame_done", int'(e.id), 8'(frame_done), 8'(e.fd));
        check("sout_r",     int'(e.id), 8'(sout_r),     8'(e.q[0]));
        check("sout_l",     int'(e.id), 8'(sout_l),     8'(e.q[WIDTH-1]));
      end
    end
  end

  task automatic step(input logic c, input logic [1:0] m, input logic sr,
                      input logic sl, input logic [3:0] p, input logic [3:0] eq,
                      input logic [1:0] ec, input logic ef);
    exp_t e;
    clr = c; mode = m; sin_r = sr; sin_l = sl; pin = p;
    e.id = 16'(step_id); e.q = eq; e.cnt = ec; e.fd = ef;
    exp_q.push_back(e);
    step_id++;
    @(posedge clk);
    #2;
  endtask

  initial begin
    clr = 1'b1; mode = 2'b11; sin_r = 1'b1; sin_l = 1'b1; pin = 4'b1111;
    #2;
    // Reset priority over load
    step(1, 2'b11, 1, 1, 4'b1111, 4'b0000, 2'd0, 0);
    step(1, 2'b11, 1, 1, 4'b1111, 4'b0000, 2'd0, 0);
    // SISO/SIPO right: 1,0,0,1 in
    step(0, 2'b01, 1, 1, 4'b1111, 4'b1000, 2'd1, 0);
    step(0, 2'b01, 0, 1, 4'b1111, 4'b0100, 2'd2, 0);
    step(0, 2'b01, 0, 1, 4'b1111, 4'b0010, 2'd3, 0);
    step(0, 2'b01, 1, 1, 4'b1111, 4'b1001, 2'd0, 1);
    // Drain: sout_r shows 1 (already), 0, 0, 1, then 0
    step(0, 2'b01, 0, 1, 4'b0000, 4'b0100, 2'd1, 0);
    step(0, 2'b01, 0, 1, 4'b0000, 4'b0010, 2'd2, 0);
    step(0, 2'b01, 0, 1, 4'b0000, 4'b0001, 2'd3, 0);
    step(0, 2'b01, 0, 1, 4'b0000, 4'b0000, 2'd0, 1);
    // PISO left
    step(0, 2'b11, 1, 1, 4'b0001, 4'b0001, 2'd0, 0);
    step(0, 2'b10, 1, 0, 4'b0000, 4'b0010, 2'd1, 0);
    step(0, 2'b10, 1, 0, 4'b0000, 4'b0100, 2'd2, 0);
    step(0, 2'b10, 1, 0, 4'b0000, 4'b1000, 2'd3, 0);
    step(0, 2'b10, 1, 0, 4'b0000, 4'b0000, 2'd0, 1);
    // Hold mid-frame, then finish the frame shifting left
    step(0, 2'b01, 1, 0, 4'b0000, 4'b1000, 2'd1, 0);
    step(0, 2'b01, 1, 0, 4'b0000, 4'b1100, 2'd2, 0);
    step(0, 2'b00, 1, 1, 4'b1111, 4'b1100, 2'd2, 0);
    step(0, 2'b00, 0, 0, 4'b0101, 4'b1100, 2'd2, 0);
    step(0, 2'b00, 1, 1, 4'b1010, 4'b1100, 2'd2, 0);
    step(0, 2'b10, 0, 1, 4'b0000, 4'b1001, 2'd3, 0);
    step(0, 2'b10, 0, 1, 4'b0000, 4'b0011, 2'd0, 1);
    // Abort by load after 3 shifts
    step(0, 2'b01, 0, 1, 4'b0000, 4'b0001, 2'd1, 0);
    step(0, 2'b01, 0, 1, 4'b0000, 4'b0000, 2'd2, 0);
    step(0, 2'b01, 0, 1, 4'b0000, 4'b0000, 2'd3, 0);
    step(0, 2'b11, 1, 1, 4'b1010, 4'b1010, 2'd0, 0);
    step(0, 2'b01, 1, 0, 4'b0000, 4'b1101, 2'd1, 0);
    step(0, 2'b01, 1, 0, 4'b0000, 4'b1110, 2'd2, 0);
    step(0, 2'b01, 1, 0, 4'b0000, 4'b1111, 2'd3, 0);
    // Clear concurrent with a would-be frame-completing shift
    step(1, 2'b01, 1, 1, 4'b1111, 4'b0000, 2'd0, 0);
    step(0, 2'b01, 1, 0, 4'b0000, 4'b1000, 2'd1, 0);
    // Continuous frames from a clean start
    step(1, 2'b00, 0, 0, 4'b0000, 4'b0000, 2'd0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 2'b01, 1, 0, 4'b0000,
           (i == 0) ? 4'b1000 : (i == 1) ? 4'b1100 : (i == 2) ? 4'b1110 : 4'b1111,
           2'((i + 1) % 4), ((i + 1) % 4) == 0);
    end
    step(0, 2'b00, 0, 0, 4'b0000, 4'b1111, 2'd0, 0);

    // Let the monitor drain, bounded
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
